// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// MEM-stage data-memory access unit for the pipelined MIPS core.
// Decodes the MEM-stage load/store, builds byte enables and lane-replicated
// store data, runs one req/ack transaction on the data bus at a time while
// stalling the pipeline, and hands completed loads to the WB-stage handler.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses
// (adel/ades pulse, bad_vaddr capture, no bus cycle). With it undefined,
// misaligned half/word accesses are silently aligned down and proceed.

module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [5:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        ld_valid,
    output logic [5:0]  ld_instr,
    output logic [1:0]  ld_addr,
    output logic [31:0] ld_data,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // TIMEOUT is at most 1023, so ten bits cover the wait counter.
    localparam int unsigned   CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Opcode decode results
    logic        is_load;
    logic        is_store;
    logic        size_byte;
    logic        size_half;
    logic        size_word;
    logic        is_access;
    logic        fault;
    logic        accept;
    logic [1:0]  eff_off;

    // Lane-steered request fields for the current MEM-stage access
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    // Sequential state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [5:0]       op_q, op_d;
    logic [1:0]       off_q, off_d;
    logic             err_q, err_d;
    logic             ldv_q, ldv_d;
    logic [5:0]       ldi_q, ldi_d;
    logic [1:0]       lda_q, lda_d;
    logic [31:0]      ldd_q, ldd_d;

`ifdef DMEM_ALIGN_CHECK_EN
    logic             misaligned;
    logic             adel_q, adel_d;
    logic             ades_q, ades_d;
    logic [31:0]      bad_q, bad_d;
`endif

    // Classify the MEM-stage opcode into load/store and access size.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_byte = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        case (mem_op)
            OP_LB, OP_LBU: begin
                is_load   = 1'b1;
                size_byte = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load   = 1'b1;
                size_half = 1'b1;
            end
            OP_LW: begin
                is_load   = 1'b1;
                size_word = 1'b1;
            end
            OP_SB: begin
                is_store  = 1'b1;
                size_byte = 1'b1;
            end
            OP_SH: begin
                is_store  = 1'b1;
                size_half = 1'b1;
            end
            OP_SW: begin
                is_store  = 1'b1;
                size_word = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign is_access = mem_valid & (is_load | is_store);

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned accesses trap, so the raw byte offset is used as-is.
    assign misaligned = (size_half & mem_addr[0]) | (size_word & (mem_addr[1:0] != 2'b00));
    assign fault      = is_access & misaligned;
    assign eff_off    = mem_addr[1:0];
`else
    // Misaligned accesses are aligned down to their natural size.
    assign fault      = 1'b0;
    assign eff_off    = size_word ? 2'b00 :
                        size_half ? {mem_addr[1], 1'b0} :
                                    mem_addr[1:0];
`endif

    assign accept = is_access & ~fault;

    // Build byte enables and replicate store data onto every lane it may hit.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = '0;
        if (is_store) begin
            if (size_byte) begin
                lane_be    = 4'b0001 << eff_off;
                lane_wdata = {4{mem_wdata[7:0]}};
            end else if (size_half) begin
                lane_be    = eff_off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{mem_wdata[15:0]}};
            end else begin
                lane_be    = 4'b1111;
                lane_wdata = mem_wdata;
            end
        end
    end

    // Transaction FSM: issue in IDLE, wait for ack or timeout in BUSY, and
    // produce the combinational pipeline stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        err_d   = 1'b0;
        ldv_d   = 1'b0;
        ldi_d   = ldi_q;
        lda_d   = lda_q;
        ldd_d   = ldd_q;
        stall   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        bad_d   = bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    be_d    = lane_be;
                    addr_d  = {mem_addr[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    op_d    = mem_op;
                    off_d   = eff_off;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
`ifdef DMEM_ALIGN_CHECK_EN
                else if (fault) begin
                    adel_d = is_load;
                    ades_d = is_store;
                    bad_d  = mem_addr;
                end
`endif
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        ldv_d = 1'b1;
                        ldi_d = op_q;
                        lda_d = off_q;
                        ldd_d = bus_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        ldv_d = 1'b1;
                        ldi_d = op_q;
                        lda_d = off_q;
                        ldd_d = '0;
                    end
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            ldv_q   <= 1'b0;
            ldi_q   <= '0;
            lda_q   <= '0;
            ldd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
            err_q   <= err_d;
            ldv_q   <= ldv_d;
            ldi_q   <= ldi_d;
            lda_q   <= lda_d;
            ldd_q   <= ldd_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Alignment-exception pulses and the captured faulting address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
            bad_q  <= '0;
        end else begin
            adel_q <= adel_d;
            ades_q <= ades_d;
            bad_q  <= bad_d;
        end
    end

    assign adel      = adel_q;
    assign ades      = ades_q;
    assign bad_vaddr = bad_q;
`else
    assign adel      = 1'b0;
    assign ades      = 1'b0;
    assign bad_vaddr = '0;
`endif

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;
    assign ld_valid  = ldv_q;
    assign ld_instr  = ldi_q;
    assign ld_addr   = lda_q;
    assign ld_data   = ldd_q;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

MEM-stage data-memory access unit for the pipelined MIPS core. Accepts the MEM-stage load/store opcode, effective address and store data, builds byte enables and lane-replicated write data, runs a req/ack transaction on the data-memory bus while stalling the pipeline, and registers the returned word with opcode and byte offset. Its registered outputs feed the WB-stage load handler, which does byte/half extraction and sign/zero extension.

## Interface

Parameters:
- TIMEOUT, 64: max BUSY cycles without bus_ack before forced completion; legal 1..1023.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  MEM-stage instruction valid.
- mem_op  in  6  opcode: 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu, 0x23 lw, 0x28 sb, 0x29 sh, 0x2B sw; any other value = no access.
- mem_addr  in  32  effective byte address.
- mem_wdata  in  32  store data (rt).
- stall  out  1  combinational; holds IF..MEM while high.
- bus_req  out  1  registered request.
- bus_we  out  1  1 = write.
- bus_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i]).
- bus_addr  out  32  word address, [1:0] always 0.
- bus_wdata  out  32  lane-replicated write data.
- bus_ack  in  1  completion, sampled only while bus_req high.
- bus_rdata  in  32  read word, valid with bus_ack on reads.
- bus_err  out  1  one-cycle pulse on timeout completion.
- ld_valid  out  1  one-cycle pulse: completed load on ld_*.
- ld_instr  out  6  opcode of completed load.
- ld_addr  out  2  mem_addr[1:0] of completed load.
- ld_data  out  32  raw read word (0 after timeout).
- adel  out  1  load address-error pulse (macro only).
- ades  out  1  store address-error pulse (macro only).
- bad_vaddr  out  32  faulting address, held until next fault.

## Operation

- Access = mem_valid & mem_op in the eight listed codes; misaligned = half op with addr[0]=1, or word op with addr[1:0]!=0.
- FSM IDLE/BUSY. IDLE: accepted (non-faulting) access -> register bus_* fields, bus_req<=1, counter<=0, go BUSY. BUSY: bus_ack -> bus_req<=0, go IDLE; else counter increments; counter==TIMEOUT-1 without ack -> bus_req<=0, bus_err<=1, go IDLE.
- stall = (IDLE & accepted access) | (BUSY & !bus_ack & counter!=TIMEOUT-1).
- Stores: sb be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; sh be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; sw be=4'b1111. Loads: bus_we=0, be=4'b1111.
- Completion of a load (ack or timeout): ld_valid<=1, ld_instr/ld_addr from latched request, ld_data<=bus_rdata (ack) or 0 (timeout). Stores: ld_valid stays 0. ld_instr/ld_addr/ld_data hold between loads.
- bus_* held stable from req rise until cycle after ack.

## Timing

- Reset: stall 0, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, bus_err 0, ld_valid 0, ld_instr 0, ld_addr 0, ld_data 0, adel 0, ades 0, bad_vaddr 0; state IDLE, counter 0.
- Cycle 0 access accepted (stall=1); cycle 1 bus_req=1; ack in cycle N>=1 -> stall=0 in N, ld_valid=1 in N+1. Zero-wait-state load = 1 stall cycle.
- Back-to-back accesses: next request issues in cycle after ack's IDLE acceptance; no overlap.
- bus_ack while bus_req=0 ignored.
- rst_n low mid-transaction: bus_req drops immediately (async), transaction abandoned, no ld_valid or bus_err.

## Configuration

- DMEM_ALIGN_CHECK_EN defined: misaligned access issues no bus cycle, no stall; next edge pulses adel (loads) or ades (stores) for one cycle and loads bad_vaddr<=mem_addr.
- Undefined: adel/ades tied 0, bad_vaddr stays 0; misaligned half ops clear addr[0], word ops clear addr[1:0] before enable/ld_addr generation; access proceeds normally.

## Test plan

- lw addr 0x100, ack same cycle as req, rdata 0xDEADBEEF -> bus_addr 0x100, be 4'hF, stall 1 cycle, ld_valid next cycle with ld_instr 0x23, ld_addr 0, ld_data 0xDEADBEEF.
- sb addr 0x203, wdata 0x12345678 -> bus_we 1, be 4'b1000, bus_addr 0x200, bus_wdata 0x78787878, ld_valid stays 0.
- sh addr 0x302, ack after 3 wait cycles -> be 4'b1100, wdata {2{0x5678}}, stall high 4 cycles, bus fields stable throughout.
- lbu addr 0x41, no ack, TIMEOUT=4 -> bus_err pulse after 4 BUSY cycles, ld_valid with ld_data 0, ld_addr 1, stall released.
- lh addr 0x11 with DMEM_ALIGN_CHECK_EN -> no bus_req, adel 1 cycle, bad_vaddr 0x11; without macro -> bus cycle, ld_addr 0.
- rst_n low during BUSY -> bus_req 0 immediately, all outputs at reset values, no ld_valid after release.
